// File: rtl/fp64_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fp64_pkg
// Description : Shared constants and types for the IEEE-754 binary64 to
//               signed 16-bit PCM converter: field widths, exponent bias,
//               converter FSM states and operand classes.
// Revision    : 1.0 - initial release
// ============================================================================
package fp64_pkg;

  localparam int BIAS   = 1023;
  localparam int EXP_W  = 11;
  localparam int FRAC_W = 52;

  localparam logic [EXP_W-1:0] EXP_ALL1 = 11'h7FF;

  // Number of cycles spent in SHIFT for every operand, so latency is fixed
  localparam int SHIFT_CYCLES = 14;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    SHIFT  = 3'd2,
    ROUND  = 3'd3,
    SAT    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    NORMAL = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } fp_class_t;

endpackage
`default_nettype wire

// File: rtl/fp64_classify.sv
`default_nettype none
// ============================================================================
// Module      : fp64_classify
// Description : Combinational field splitter / classifier for a binary64
//               operand.
//   operand  in  64  IEEE-754 binary64 value
//   sign     out 1   sign bit
//   cls      out 2   ZERO (zero or subnormal), NORMAL, INF, NAN
//   exp_unb  out 12  unbiased exponent E - 1023 (signed)
//   mant     out 53  significand {hidden bit, fraction}
// Revision    : 1.0 - initial release
// ============================================================================
module fp64_classify
  import fp64_pkg::*;
(
  input  logic [63:0]        operand,
  output logic               sign,
  output fp_class_t          cls,
  output logic signed [11:0] exp_unb,
  output logic [52:0]        mant
);

  logic [EXP_W-1:0]  exp_field;
  logic [FRAC_W-1:0] frac_field;

  assign sign       = operand[63];
  assign exp_field  = operand[62:FRAC_W];
  assign frac_field = operand[FRAC_W-1:0];

  always_comb begin
    cls = NORMAL;
    if (exp_field == EXP_ALL1) begin
      cls = (frac_field != '0) ? NAN : INF;
    end else if (exp_field == '0) begin
      cls = ZERO;
    end
  end

  assign exp_unb = $signed({1'b0, exp_field}) - 12'(BIAS);

  // Hidden bit is only present for normal numbers
  assign mant = {(exp_field != '0), frac_field};

endmodule
`default_nettype wire

// File: rtl/double_to_sig16b_rne.sv
`default_nettype none
// ============================================================================
// Module      : double_to_sig16b_rne
// Description : Multi-cycle binary64 -> signed 16-bit PCM converter. Scales by
//               2^SCALE_EXP, rounds to nearest-even and saturates. Fixed
//               latency of 18 clock edges from the accepting edge.
//   clk_operation in  1   operation clock, rising edge
//   rst           in  1   asynchronous active-low reset
//   enable        in  1   start pulse, accepted only in IDLE
//   double        in  64  binary64 operand, captured on accept
//   sig16b        out 16  two's-complement result, held until next completion
//   ready         out 1   sig16b valid for the last accepted operand
//   sat_flag      out 1   last result clipped (includes +/-Inf)
//   invalid_flag  out 1   last operand was NaN
// Revision    : 1.0 - initial release
// ============================================================================
module double_to_sig16b_rne
  import fp64_pkg::*;
#(
  parameter int SCALE_EXP  = 15,
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk_operation,
  input  logic        rst,
  input  logic        enable,
  input  logic [63:0] double,
  output logic [15:0] sig16b,
  output logic        ready,
  output logic        sat_flag,
  output logic        invalid_flag
);

  // Largest representable integer exponent for a 16-bit signed result
  localparam int         K_MAX      = 15;
  localparam int         MAX_SHIFT  = 56;
  localparam logic [5:0] STEP6      = 6'(SHIFT_STEP);
  localparam logic [5:0] MAX6       = 6'(MAX_SHIFT);
  localparam logic [3:0] LAST_SHIFT = 4'(SHIFT_CYCLES - 1);

  state_t state, state_next;

  logic               unpack_phase;
  logic [3:0]         shift_cnt;
  logic [63:0]        operand;

  logic               sign_q;
  fp_class_t          cls_q;
  logic signed [11:0] exp_q;
  logic [52:0]        mant_q;
  logic [5:0]         rem_q;
  logic               guard_q;
  logic               sticky_q;
  logic               force_zero_q;
  logic               force_sat_q;
  logic               nan_q;
  logic [16:0]        mag_q;

  // --------------------------------------------------------------------------
  // Classifier on the captured operand
  // --------------------------------------------------------------------------
  logic               cls_sign;
  fp_class_t          cls_class;
  logic signed [11:0] cls_exp;
  logic [52:0]        cls_mant;

  fp64_classify u_classify (
    .operand (operand),
    .sign    (cls_sign),
    .cls     (cls_class),
    .exp_unb (cls_exp),
    .mant    (cls_mant)
  );

  // --------------------------------------------------------------------------
  // UNPACK decode: integer exponent k, shift count r and special cases.
  // Evaluated from the registered classifier outputs in the second UNPACK
  // cycle; splitting UNPACK over two cycles keeps the classifier and the
  // exponent arithmetic in separate register stages.
  // --------------------------------------------------------------------------
  logic signed [12:0] k_val;
  logic signed [12:0] r_val;
  logic [5:0]         rem_load;
  logic               frac_zero;
  logic               force_sat_load;
  logic               force_zero_load;

  assign k_val     = 13'(exp_q) + 13'(SCALE_EXP);
  assign r_val     = 13'sd52 - k_val;
  assign frac_zero = (mant_q[FRAC_W-1:0] == '0);

  always_comb begin
    if (r_val < 13'sd0) begin
      rem_load = 6'd0;
    end else if (r_val > 13'(MAX_SHIFT)) begin
      rem_load = MAX6;
    end else begin
      rem_load = r_val[5:0];
    end
  end

  // k == K_MAX only survives the datapath for exactly -2^15 (s=1, F=0);
  // every other k >= K_MAX operand is forced to saturation.
  assign force_sat_load = (cls_q == INF) ||
                          ((cls_q == NORMAL) &&
                           ((k_val > 13'(K_MAX)) ||
                            ((k_val == 13'(K_MAX)) && !(sign_q && frac_zero))));

  assign force_zero_load = (cls_q == ZERO) ||
                           ((cls_q == NORMAL) && (k_val < -13'sd1));

  // --------------------------------------------------------------------------
  // SHIFT step: move right by min(SHIFT_STEP, remaining). The last bit out
  // becomes guard; the previous guard and all other bits out fold into sticky.
  // --------------------------------------------------------------------------
  logic [5:0]  shift_n;
  logic [52:0] low_mask;
  logic [52:0] shift_mant;
  logic        shift_guard;
  logic        shift_sticky;

  always_comb begin
    shift_n      = (rem_q > STEP6) ? STEP6 : rem_q;
    low_mask     = '0;
    shift_mant   = mant_q;
    shift_guard  = guard_q;
    shift_sticky = sticky_q;
    if (shift_n != 6'd0) begin
      low_mask     = (53'd1 << (shift_n - 6'd1)) - 53'd1;
      shift_guard  = mant_q[shift_n - 6'd1];
      shift_sticky = sticky_q | guard_q | (|(mant_q & low_mask));
      shift_mant   = mant_q >> shift_n;
    end
  end

  // --------------------------------------------------------------------------
  // ROUND: nearest-even on the integer part; 17 bits keep a carry into 2^15
  // --------------------------------------------------------------------------
  logic        round_up;
  logic [16:0] rounded;

  assign round_up = guard_q & (sticky_q | mant_q[0]);
  assign rounded  = {1'b0, mant_q[15:0]} + 17'(round_up);

  // --------------------------------------------------------------------------
  // SAT: clip and apply sign
  // --------------------------------------------------------------------------
  logic [15:0] result;
  logic        result_sat;
  logic        result_inv;

  always_comb begin
    result     = 16'h0000;
    result_sat = 1'b0;
    result_inv = 1'b0;
    if (nan_q) begin
      result_inv = 1'b1;
    end else if (force_sat_q) begin
      result     = sign_q ? 16'h8000 : 16'h7FFF;
      result_sat = 1'b1;
    end else if (!sign_q) begin
      if (mag_q >= 17'd32768) begin
        result     = 16'h7FFF;
        result_sat = 1'b1;
      end else begin
        result = mag_q[15:0];
      end
    end else begin
      if (mag_q > 17'd32768) begin
        result     = 16'h8000;
        result_sat = 1'b1;
      end else if (mag_q == 17'd32768) begin
        result = 16'h8000;
      end else begin
        result = ~mag_q[15:0] + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = UNPACK;
      UNPACK:  if (unpack_phase) state_next = SHIFT;
      SHIFT:   if (shift_cnt == LAST_SHIFT) state_next = ROUND;
      ROUND:   state_next = SAT;
      SAT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) begin
      unpack_phase <= 1'b0;
      shift_cnt    <= 4'd0;
      operand      <= 64'd0;
      sign_q       <= 1'b0;
      cls_q        <= ZERO;
      exp_q        <= 12'sd0;
      mant_q       <= 53'd0;
      rem_q        <= 6'd0;
      guard_q      <= 1'b0;
      sticky_q     <= 1'b0;
      force_zero_q <= 1'b0;
      force_sat_q  <= 1'b0;
      nan_q        <= 1'b0;
      mag_q        <= 17'd0;
      sig16b       <= 16'h0000;
      ready        <= 1'b0;
      sat_flag     <= 1'b0;
      invalid_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            operand      <= double;
            ready        <= 1'b0;
            unpack_phase <= 1'b0;
          end
        end
        UNPACK: begin
          if (!unpack_phase) begin
            sign_q       <= cls_sign;
            cls_q        <= cls_class;
            exp_q        <= cls_exp;
            mant_q       <= cls_mant;
            unpack_phase <= 1'b1;
          end else begin
            rem_q        <= rem_load;
            guard_q      <= 1'b0;
            sticky_q     <= 1'b0;
            force_zero_q <= force_zero_load;
            force_sat_q  <= force_sat_load;
            nan_q        <= (cls_q == NAN);
            shift_cnt    <= 4'd0;
          end
        end
        SHIFT: begin
          mant_q    <= shift_mant;
          guard_q   <= shift_guard;
          sticky_q  <= shift_sticky;
          rem_q     <= rem_q - shift_n;
          shift_cnt <= shift_cnt + 4'd1;
        end
        ROUND: begin
          mag_q <= force_zero_q ? 17'd0 : rounded;
        end
        SAT: begin
          sig16b       <= result;
          sat_flag     <= result_sat;
          invalid_flag <= result_inv;
          ready        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_double_to_sig16b_rne.sv
`default_nettype none
// ============================================================================
// Module      : tb_double_to_sig16b_rne
// Description : Directed self-checking bench for double_to_sig16b_rne.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_double_to_sig16b_rne;

  logic        clk_operation;
  logic        rst;
  logic        enable;
  logic [63:0] double;
  logic [15:0] sig16b;
  logic        ready;
  logic        sat_flag;
  logic        invalid_flag;

  int checks;
  int failures;

  double_to_sig16b_rne #(
    .SCALE_EXP  (15),
    .SHIFT_STEP (4)
  ) dut (
    .clk_operation (clk_operation),
    .rst           (rst),
    .enable        (enable),
    .double        (double),
    .sig16b        (sig16b),
    .ready         (ready),
    .sat_flag      (sat_flag),
    .invalid_flag  (invalid_flag)
  );

  initial clk_operation = 1'b0;
  always #5 clk_operation = ~clk_operation;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, expv);
    end
  endtask

  // Accept operand d on the next rising edge, then track 18 edges.
  // busy_at (1..18) injects an enable with busy_d sampled on that edge.
  task automatic run_conv(input string tag, input logic [63:0] d,
                          input logic [15:0] exp_res, input logic exp_sat,
                          input logic exp_inv, input int busy_at,
                          input logic [63:0] busy_d);
    @(negedge clk_operation);
    enable = 1'b1;
    double = d;
    @(posedge clk_operation);
    #1;
    enable = 1'b0;
    double = 64'h0;
    chk({tag, "_ready_clr"}, {15'd0, ready}, 16'd0);
    for (int e = 1; e <= 18; e++) begin
      @(negedge clk_operation);
      if (e == busy_at) begin
        enable = 1'b1;
        double = busy_d;
      end
      @(posedge clk_operation);
      #1;
      enable = 1'b0;
      double = 64'h0;
      if (e == 17) chk({tag, "_ready_e17"}, {15'd0, ready}, 16'd0);
    end
    chk({tag, "_ready"}, {15'd0, ready}, 16'd1);
    chk({tag, "_sig"}, sig16b, exp_res);
    chk({tag, "_sat"}, {15'd0, sat_flag}, {15'd0, exp_sat});
    chk({tag, "_inv"}, {15'd0, invalid_flag}, {15'd0, exp_inv});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    enable   = 1'b0;
    double   = 64'h0;

    // Reset state
    repeat (3) @(negedge clk_operation);
    chk("reset_sig", sig16b, 16'h0000);
    chk("reset_ready", {15'd0, ready}, 16'd0);
    chk("reset_sat", {15'd0, sat_flag}, 16'd0);
    chk("reset_inv", {15'd0, invalid_flag}, 16'd0);
    rst = 1'b1;
    @(negedge clk_operation);

    // Conversions and saturation boundaries (consecutive calls are back-to-back)
    run_conv("half",      64'h3FE0000000000000, 16'h4000, 1'b0, 1'b0, 0, 64'h0);
    run_conv("neg_one",   64'hBFF0000000000000, 16'h8000, 1'b0, 1'b0, 0, 64'h0);
    run_conv("pos_one",   64'h3FF0000000000000, 16'h7FFF, 1'b1, 1'b0, 0, 64'h0);
    run_conv("neg_one_p", 64'hBFF0000000000001, 16'h8000, 1'b1, 1'b0, 0, 64'h0);
    run_conv("carry_sat", 64'h3FEFFFF000000000, 16'h7FFF, 1'b1, 1'b0, 0, 64'h0);
    run_conv("neg_qtr",   64'hBFD0000000000000, 16'hE000, 1'b0, 1'b0, 0, 64'h0);

    // RNE ties
    run_conv("tie_0p5",   64'h3EF0000000000000, 16'h0000, 1'b0, 1'b0, 0, 64'h0);
    run_conv("tie_1p5",   64'h3F08000000000000, 16'h0002, 1'b0, 1'b0, 0, 64'h0);
    run_conv("tie_2p5",   64'h3F14000000000000, 16'h0002, 1'b0, 1'b0, 0, 64'h0);
    run_conv("above_2p5", 64'h3F14000000000001, 16'h0003, 1'b0, 1'b0, 0, 64'h0);

    // Special operands
    run_conv("nan",       64'h7FF8000000000000, 16'h0000, 1'b0, 1'b1, 0, 64'h0);
    run_conv("neg_inf",   64'hFFF0000000000000, 16'h8000, 1'b1, 1'b0, 0, 64'h0);
    run_conv("neg_zero",  64'h8000000000000000, 16'h0000, 1'b0, 1'b0, 0, 64'h0);
    run_conv("subnormal", 64'h0000000000000001, 16'h0000, 1'b0, 1'b0, 0, 64'h0);

    // Enable on the completion edge is ignored: ready must stay high after it
    run_conv("done_edge", 64'hBFD0000000000000, 16'hE000, 1'b0, 1'b0, 18, 64'h3FF0000000000000);
    repeat (3) @(posedge clk_operation);
    #1;
    chk("done_edge_hold_ready", {15'd0, ready}, 16'd1);
    chk("done_edge_hold_sig", sig16b, 16'hE000);

    // Enable while busy (edge 5) is ignored; first operand's result delivered
    run_conv("busy", 64'h3FE0000000000000, 16'h4000, 1'b0, 1'b0, 5, 64'hBFF0000000000000);

    // Leave a non-zero result, then reset in the middle of the next conversion
    run_conv("pre_rst", 64'h3F14000000000000, 16'h0002, 1'b0, 1'b0, 0, 64'h0);
    @(negedge clk_operation);
    enable = 1'b1;
    double = 64'h3FF0000000000000;
    @(posedge clk_operation);
    #1;
    enable = 1'b0;
    double = 64'h0;
    repeat (9) @(posedge clk_operation);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_sig", sig16b, 16'h0000);
    chk("midrst_ready", {15'd0, ready}, 16'd0);
    @(negedge clk_operation);
    @(negedge clk_operation);
    rst = 1'b1;

    // Normal conversion after release
    run_conv("post_rst", 64'h3FE0000000000000, 16'h4000, 1'b0, 1'b0, 0, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
